// File: rtl/prog_loader_if.sv
// ROM read port and target write bus between prog_loader and its surroundings.
interface prog_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rom_addr,
    input  rom_data,
    output wr_valid,
    input  wr_ready,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  wr_valid,
    output wr_ready,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// Copies a program image from a synchronous ROM to a target write port after a
// debounced push-button start. Optional feature macro: PROG_LOADER_CHECKSUM_EN
// (running sum of accepted words, csum_ok when the sum is zero at the end).
module prog_loader #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  start_btn,
  input  logic [ADDR_WIDTH:0]   xfer_len,
  prog_loader_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            progress,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  csum_ok
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned PROG_W = CNT_W + 4;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_e;

  logic [1:0]      sync_q;
  logic            deb_q, deb_prev_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            start_c;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   wr_valid_q, wr_valid_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]             progress_q, progress_d;
  logic [PROG_W-1:0]      prog_quo;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  csum_q, csum_d;
  logic                   csum_ok_q, csum_ok_d;
`endif

  // Synchronize the raw button and flip the debounced level only after a full run of equal samples.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync_q     <= {sync_q[0], start_btn};
      deb_prev_q <= deb_q;
      if (sync_q[1] == deb_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q    <= sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  assign start_c = deb_q & ~deb_prev_q;

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    rom_addr_d = rom_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    cnt_inc    = cnt_q + CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    csum_ok_d  = csum_ok_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d    = READ;
          len_d      = (xfer_len == '0 || xfer_len > FULL_LEN) ? FULL_LEN : xfer_len;
          cnt_d      = '0;
          rom_addr_d = '0;
          done_d     = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = '0;
          csum_ok_d  = 1'b0;
`endif
        end
      end
      READ: state_d = LATCH;
      LATCH: begin
        wr_data_d  = bus.rom_data;
        wr_addr_d  = rom_addr_q;
        wr_valid_d = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        if (wr_valid_q && bus.wr_ready) begin
          cnt_d      = cnt_inc;
          wr_valid_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = csum_q + wr_data_q;
`endif
          if (cnt_inc == len_q) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_ok_d = (csum_d == '0);
`endif
          end else begin
            state_d    = READ;
            rom_addr_d = cnt_inc[ADDR_WIDTH-1:0];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == READ) || (state_d == LATCH) || (state_d == WRITE);
    // Progress is the word count scaled to 16ths of the effective length, saturated at F.
    prog_quo   = (len_d == '0) ? '0 : PROG_W'({cnt_d, 4'b0000}) / PROG_W'(len_d);
    progress_d = (prog_quo > PROG_W'(15)) ? 4'hF : prog_quo[3:0];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      rom_addr_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      progress_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      csum_ok_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      rom_addr_q <= rom_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      progress_q <= progress_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_ok_q  <= csum_ok_d;
`endif
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign progress     = progress_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign checksum     = csum_q;
  assign csum_ok      = csum_ok_q;
`else
  assign checksum     = '0;
  assign csum_ok      = done_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: ROM model, ready driver, write monitor and
// a transfer-level reference model (expected writes, checksum, progress).
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEB   = 64;
  localparam int unsigned DEPTH = 256;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          s_reset;
  logic          start_btn;
  logic [AW:0]   xfer_len;
  logic          busy, done, csum_ok;
  logic [3:0]    progress;
  logic [DW-1:0] checksum;

  prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .s_reset(s_reset), .start_btn(start_btn), .xfer_len(xfer_len),
    .bus(bus), .busy(busy), .done(done), .progress(progress),
    .checksum(checksum), .csum_ok(csum_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Synchronous ROM: data for an address appears one cycle later.
  logic [DW-1:0] rom [DEPTH];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Target ready: 0 always ready, 1 random, 2 five stall cycles per word.
  int ready_mode = 0;
  int vcnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.wr_ready = 1'b1;
      1: bus.wr_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (!bus.wr_valid) vcnt = 0;
        else vcnt++;
        bus.wr_ready = (vcnt > 5);
      end
    endcase
  end

  function automatic int eff_len(input int x);
    return (x == 0 || x > int'(DEPTH)) ? int'(DEPTH) : x;
  endfunction

  function automatic int prog_model(input int n, input int len);
    int p;
    p = (n * 16) / len;
    return (p > 15) ? 15 : p;
  endfunction

  // Monitor: collects accepted writes, counts starts, checks stall stability and progress.
  wr_t           got[$];
  int            starts = 0;
  int            busy_cycles = 0;
  int            cur_len = 1;
  logic          busy_prev = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  always @(negedge clk) begin
    if (s_reset) begin
      hold      = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) starts++;
      busy_prev = busy;
      if (busy) begin
        busy_cycles++;
        chk("progress", 64'(progress), 64'(prog_model(got.size(), cur_len)));
      end
      if (hold) begin
        chk("stall_valid", 64'(bus.wr_valid), 64'(1));
        chk("stall_addr", 64'(bus.wr_addr), 64'(hold_a));
        chk("stall_data", 64'(bus.wr_data), 64'(hold_d));
      end
      hold   = bus.wr_valid && !bus.wr_ready;
      hold_a = bus.wr_addr;
      hold_d = bus.wr_data;
      if (bus.wr_valid && bus.wr_ready) got.push_back('{a: bus.wr_addr, d: bus.wr_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 4 * int'(DEB)) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int el);
    int n = 0;
    while (!done && n < 20 * el + 200) begin
      tick(1);
      n++;
    end
    chk("done", 64'(done), 64'(1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'(0));
    chk({tag, "_wr_valid"}, 64'(bus.wr_valid), 64'(0));
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'(0));
    chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_progress"}, 64'(progress), 64'(0));
    chk({tag, "_checksum"}, 64'(checksum), 64'(0));
    chk({tag, "_csum_ok"}, 64'(csum_ok), 64'(0));
  endtask

  // Compare the collected writes and the final status against the model of one transfer.
  task automatic check_image(input int el);
    logic [DW-1:0] sum = '0;
    chk("nwrites", 64'(got.size()), 64'(el));
    for (int i = 0; i < el && i < got.size(); i++) begin
      chk("wr_addr", 64'(got[i].a), 64'(i));
      chk("wr_data", 64'(got[i].d), 64'(rom[i]));
    end
    for (int i = 0; i < el; i++) sum += rom[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(sum));
    chk("csum_ok", 64'(csum_ok), 64'(sum == '0));
`else
    chk("checksum", 64'(checksum), 64'(0));
    chk("csum_ok", 64'(csum_ok), 64'(done));
`endif
  endtask

  task automatic run_transfer(input int len_in, input int mode, input int extra_hold);
    int el = eff_len(len_in);
    int s0 = starts;
    ready_mode  = mode;
    xfer_len    = LW'(len_in);
    cur_len     = el;
    got.delete();
    busy_cycles = 0;
    start_btn   = 1'b1;
    wait_busy("start_seen");
    chk("done_cleared", 64'(done), 64'(0));
    wait_done(el);
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("progress_done", 64'(progress), 64'(15));
    tick(extra_hold);
    start_btn = 1'b0;
    tick(int'(DEB) + 10);
    chk("done_held", 64'(done), 64'(1));
    chk("starts", 64'(starts - s0), 64'(1));
    if (mode == 0) chk("throughput", 64'(busy_cycles <= 3 * el), 64'(1));
    check_image(el);
  endtask

  initial begin
    int s0;
    int n;
    s_reset   = 1'b1;
    start_btn = 1'b0;
    xfer_len  = '0;
    tick(3);
    check_reset("por");
    s_reset = 1'b0;
    tick(2);

    // Full-depth transfer of the counting image.
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = DW'(i + 1);
    run_transfer(0, 0, 0);

    // Short transfer with a stalling target.
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
    run_transfer(4, 2, 0);

    // Length boundaries and randomized lengths against a random-ready target.
    run_transfer(1, 1, 0);
    run_transfer(257, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
      run_transfer(int'($urandom_range(0, 300)), 1, 0);
    end

    // Short glitch must not start; a long hold starts exactly once.
    s0 = starts;
    start_btn = 1'b1;
    tick(int'(DEB) / 2);
    start_btn = 1'b0;
    tick(3 * int'(DEB));
    chk("glitch_no_start", 64'(starts - s0), 64'(0));
    run_transfer(5, 1, 6 * int'(DEB));

    // Second press during a transfer is ignored.
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
    ready_mode = 0;
    xfer_len   = '0;
    cur_len    = int'(DEPTH);
    got.delete();
    s0 = starts;
    start_btn = 1'b1;
    wait_busy("busy_first");
    tick(int'(DEB) + 20);
    start_btn = 1'b0;
    tick(int'(DEB) + 20);
    start_btn = 1'b1;
    tick(int'(DEB) + 20);
    chk("busy_during_repress", 64'(busy), 64'(1));
    start_btn = 1'b0;
    wait_done(int'(DEPTH));
    tick(int'(DEB) + 10);
    chk("ignored_starts", 64'(starts - s0), 64'(1));
    check_image(int'(DEPTH));

    // New start after done clears done and runs again.
    run_transfer(6, 0, 0);

    // Checksum image with complement word, then without.
    rom[0] = 32'd5;
    rom[1] = 32'd7;
    rom[2] = 32'hFFFF_FFF4;
    run_transfer(3, 0, 0);
    rom[2] = 32'd0;
    run_transfer(3, 1, 0);

    // Reset after ten accepted writes aborts the transfer.
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
    ready_mode = 0;
    xfer_len   = '0;
    cur_len    = int'(DEPTH);
    got.delete();
    start_btn = 1'b1;
    wait_busy("busy_before_reset");
    start_btn = 1'b0;
    n = 0;
    while (got.size() < 10 && n < 200) begin
      tick(1);
      n++;
    end
    chk("ten_accepted", 64'(got.size()), 64'(10));
    s_reset = 1'b1;
    tick(1);
    check_reset("rst_mid");
    s_reset = 1'b0;
    tick(3 * int'(DEB));
    chk("no_writes_after_reset", 64'(got.size()), 64'(10));
    chk("idle_after_reset", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
